// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial lookahead adder: FSM encodings
// and the slice width.
package cla_nibble_serial_adder_pkg;

  localparam int NIBW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_4_augment.sv
// 4-bit carry-lookahead slice that also exports group propagate/generate so
// a caller can compute the next nibble's carry without rippling through it.
import cla_nibble_serial_adder_pkg::*;

module bit_4_augment (
  input  logic [NIBW-1:0] a,
  input  logic [NIBW-1:0] b,
  input  logic            cin,
  output logic [NIBW-1:0] s,
  output logic            p,
  output logic            g
);

  logic [NIBW-1:0] bp;
  logic [NIBW-1:0] bg;
  logic [NIBW-1:0] c;

  assign bp = a ^ b;
  assign bg = a & b;

  assign c[0] = cin;
  assign c[1] = bg[0] | (bp[0] & cin);
  assign c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
  assign c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
              | (bp[2] & bp[1] & bp[0] & cin);

  assign s = bp ^ c;

  // Group terms exclude cin so the caller forms g | (p & carry) itself.
  assign p = &bp;
  assign g = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
           | (bp[3] & bp[2] & bp[1] & bg[0]);

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit lookahead slice per
// nibble, handing results off through a start/busy/done handshake.
import cla_nibble_serial_adder_pkg::*;

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIBW;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [IDXW-1:0]  idx;
  logic             carry;

  logic [NIBW-1:0]  a_nib;
  logic [NIBW-1:0]  b_nib;
  logic [NIBW-1:0]  nib_s;
  logic             grp_p;
  logic             grp_g;
  logic             carry_nx;

  assign a_nib    = a_lat[NIBW*idx +: NIBW];
  assign b_nib    = b_lat[NIBW*idx +: NIBW];
  assign carry_nx = grp_g | (grp_p & carry);

  bit_4_augment u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry),
    .s   (nib_s),
    .p   (grp_p),
    .g   (grp_g)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Only the nibble addressed by idx is written, so S keeps the previous
  // result in the nibbles not yet reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_lat <= '0;
      b_lat <= '0;
      idx   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat <= A;
            b_lat <= B;
            idx   <= '0;
            carry <= cin;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          S[NIBW*idx +: NIBW] <= nib_s;
          carry <= carry_nx;
          if (idx == LAST) begin
            idx  <= '0;
            cout <= carry_nx;
            ovf  <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) &&
                    (nib_s[NIBW-1] != a_lat[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed self-checking bench for the nibble-serial lookahead adder.
module tb_cla_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  cla_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .S     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int id,
                             input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Pulses start for one cycle and waits for done; lat counts edges from
  // the accepting edge to the edge that raised done (-1 on timeout).
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic ci, output int lat,
                               output bit busy_ok);
    int edges;
    busy_ok = 1'b1;
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
    lat = done ? edges - 1 : -1;
  endtask

  task automatic runVector(input int id, input vec_t v);
    int lat;
    bit busy_ok;
    applyStimulus(v.a, v.b, v.cin, lat, busy_ok);
    checkOutput("latency", id, lat, 5);
    checkOutput("busy_during_run", id, {31'd0, busy_ok}, 1);
    checkOutput("busy_at_done", id, {31'd0, busy}, 0);
    checkOutput("sum", id, {16'd0, s}, {16'd0, v.s});
    checkOutput("cout", id, {31'd0, cout}, {31'd0, v.cout});
    checkOutput("ovf", id, {31'd0, ovf}, {31'd0, v.ovf});
  endtask

  initial begin
    int dones;
    int cyc;
    int done_cyc[$];
    logic [15:0] done_s[$];
    logic [15:0] bb_a[3];
    int bb_i;

    n_cmp = 0;
    n_bad = 0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h89AB, 16'h7654, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 0, {31'd0, busy}, 0);
    checkOutput("reset_done", 0, {31'd0, done}, 0);
    checkOutput("reset_sum", 0, {16'd0, s}, 0);
    checkOutput("reset_cout", 0, {31'd0, cout}, 0);
    checkOutput("reset_ovf", 0, {31'd0, ovf}, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) runVector(i, vecs[i]);

    // Results hold after done until the next start.
    repeat (4) @(negedge clk);
    checkOutput("hold_sum", 0, {16'd0, s}, 32'h0000FFFF);
    checkOutput("hold_done", 0, {31'd0, done}, 0);

    // Start pulse two cycles into a busy addition must be ignored.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h7000; b = 16'h0123; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        checkOutput("busy_ign_sum", i, {16'd0, s}, 32'h00003333);
      end
      @(negedge clk);
    end
    checkOutput("busy_ign_dones", 0, dones, 1);

    // Start held high: back-to-back, each re-sampling operands.
    bb_a[0] = 16'h0100; bb_a[1] = 16'h0200; bb_a[2] = 16'h0300;
    bb_i = 0;
    a = bb_a[0]; b = 16'h0005; cin = 1'b0; start = 1'b1;
    cyc = 0;
    while (done_cyc.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cyc.push_back(cyc);
        done_s.push_back(s);
        bb_i++;
        if (bb_i < 3) a = bb_a[bb_i];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("b2b_count", 0, done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      checkOutput("b2b_gap", 0, done_cyc[1] - done_cyc[0], 6);
      checkOutput("b2b_gap", 1, done_cyc[2] - done_cyc[1], 6);
      checkOutput("b2b_sum", 0, {16'd0, done_s[0]}, 32'h00000105);
      checkOutput("b2b_sum", 1, {16'd0, done_s[1]}, 32'h00000205);
      checkOutput("b2b_sum", 2, {16'd0, done_s[2]}, 32'h00000305);
    end
    repeat (8) @(negedge clk);

    // Asynchronous reset between edges in the middle of RUN.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_busy", 0, {31'd0, busy}, 0);
    checkOutput("async_done", 0, {31'd0, done}, 0);
    checkOutput("async_sum", 0, {16'd0, s}, 0);
    checkOutput("async_cout", 0, {31'd0, cout}, 0);
    checkOutput("async_ovf", 0, {31'd0, ovf}, 0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    checkOutput("post_reset_quiet", 0, dones, 0);
    runVector(100, vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
